// File: rtl/ad100_memory.sv
// Unified instruction/data memory for the ad100 CPU with a byte-stream boot loader.
// Port 1 fetches, port 2 reads/writes with byte lanes; the loader fills the array after reset while holding the CPU.
module ad100_memory #(
  parameter int ADDR_BITS = 10,
  parameter bit SKIP_LOAD = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr_1,
  output logic [31:0] read_1,
  input  logic [29:0] addr_2,
  output logic [31:0] read_2,
  input  logic [31:0] write_2,
  input  logic        write_enable_1,
  input  logic        write_enable_2,
  input  logic        write_enable_3,
  input  logic        write_enable_4,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_overflow,
  output logic        debug_state
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_t;

  // Handshake: a loader byte transfers on a rising edge where load_valid && load_ready;
  // load_ready is a registered copy of the LOAD state, so it never depends on load_valid.
  state_t                 state;
  logic [31:0]            mem [DEPTH];
  logic [1:0]             byte_cnt;
  logic [ADDR_BITS-1:0]   word_ptr;
  logic [31:0]            word_buf;
  logic [31:0]            word_next;
  logic                   accept;
  logic                   word_done;
  logic                   ptr_at_end;
  logic                   in_range_1;
  logic                   in_range_2;
  logic [3:0]             lane_we;

  assign debug_state = (state == ST_RUN);

  assign in_range_1 = ((addr_1 >> ADDR_BITS) == '0);
  assign in_range_2 = ((addr_2 >> ADDR_BITS) == '0);
  assign read_1     = in_range_1 ? mem[addr_1[ADDR_BITS-1:0]] : 32'h0000_0000;
  assign read_2     = in_range_2 ? mem[addr_2[ADDR_BITS-1:0]] : 32'h0000_0000;

  assign lane_we    = {write_enable_4, write_enable_3, write_enable_2, write_enable_1};
  assign accept     = load_valid && load_ready;
  assign word_done  = accept && ((byte_cnt == 2'd3) || load_last);
  assign ptr_at_end = (word_ptr == '1);

  // The buffer is kept cleared above the current lane, so a short final word pads with zeros.
  always_comb begin
    word_next = word_buf;
    for (int i = 0; i < 4; i++) begin
      if (byte_cnt == 2'(i)) word_next[8*i +: 8] = load_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= SKIP_LOAD ? ST_RUN : ST_LOAD;
      load_ready    <= !SKIP_LOAD;
      cpu_hold      <= !SKIP_LOAD;
      byte_cnt      <= 2'd0;
      word_ptr      <= '0;
      word_buf      <= 32'h0000_0000;
      load_overflow <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        word_buf <= 32'h0000_0000;
        byte_cnt <= 2'd0;
        word_ptr <= word_ptr + 1'b1;
        if (load_last || ptr_at_end) begin
          state      <= ST_RUN;
          load_ready <= 1'b0;
          cpu_hold   <= 1'b0;
        end
        if (!load_last && ptr_at_end) load_overflow <= 1'b1;
      end else begin
        word_buf <= word_next;
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  // The array has no reset; a reset edge suppresses both loader and CPU writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (word_done) begin
        mem[word_ptr] <= word_next;
      end else if (state == ST_RUN && in_range_2) begin
        for (int i = 0; i < 4; i++) begin
          if (lane_we[i]) mem[addr_2[ADDR_BITS-1:0]][8*i +: 8] <= write_2[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ad100_memory.sv
// Directed bench for ad100_memory: loader, RUN-mode byte-lane writes, range checks,
// reset mid-load, overflow with a tiny array and the SKIP_LOAD reset state.
module tb_ad100_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Main instance, ADDR_BITS=10
  logic        reset = 1'b1;
  logic [29:0] addr_1 = '0, addr_2 = '0;
  logic [31:0] read_1, read_2, write_2 = '0;
  logic        we1 = 0, we2 = 0, we3 = 0, we4 = 0;
  logic        load_valid = 0, load_last = 0;
  logic [7:0]  load_byte = '0;
  logic        load_ready, cpu_hold, load_overflow, dbg_a;

  ad100_memory #(.ADDR_BITS(10), .SKIP_LOAD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .addr_1(addr_1), .read_1(read_1), .addr_2(addr_2), .read_2(read_2),
    .write_2(write_2), .write_enable_1(we1), .write_enable_2(we2), .write_enable_3(we3),
    .write_enable_4(we4), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .cpu_hold(cpu_hold), .load_overflow(load_overflow), .debug_state(dbg_a)
  );

  // Small instance for overflow, ADDR_BITS=2
  logic        b_reset = 1'b1;
  logic [29:0] b_addr_1 = '0, b_addr_2 = '0;
  logic [31:0] b_read_1, b_read_2;
  logic        b_valid = 0;
  logic [7:0]  b_byte = '0;
  logic        b_ready, b_hold, b_overflow, dbg_b;

  ad100_memory #(.ADDR_BITS(2), .SKIP_LOAD(1'b0)) dut_b (
    .clk(clk), .reset(b_reset), .addr_1(b_addr_1), .read_1(b_read_1), .addr_2(b_addr_2), .read_2(b_read_2),
    .write_2(32'h0), .write_enable_1(1'b0), .write_enable_2(1'b0), .write_enable_3(1'b0),
    .write_enable_4(1'b0), .load_valid(b_valid), .load_byte(b_byte), .load_last(1'b0),
    .load_ready(b_ready), .cpu_hold(b_hold), .load_overflow(b_overflow), .debug_state(dbg_b)
  );

  // SKIP_LOAD instance, shares the main reset
  logic [31:0] c_read_1, c_read_2;
  logic        c_ready, c_hold, c_overflow, dbg_c;

  ad100_memory #(.ADDR_BITS(10), .SKIP_LOAD(1'b1)) dut_c (
    .clk(clk), .reset(reset), .addr_1(30'h0), .read_1(c_read_1), .addr_2(30'h0), .read_2(c_read_2),
    .write_2(32'h0), .write_enable_1(1'b0), .write_enable_2(1'b0), .write_enable_3(1'b0),
    .write_enable_4(1'b0), .load_valid(1'b0), .load_byte(8'h0), .load_last(1'b0),
    .load_ready(c_ready), .cpu_hold(c_hold), .load_overflow(c_overflow), .debug_state(dbg_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic reset_a();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] prog8 [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] prog5 [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

  initial begin
    // Reset
    tick();
    tick();
    reset   = 1'b0;
    b_reset = 1'b0;
    check("rst_load_ready", {31'b0, load_ready}, 32'd1);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check("rst_overflow", {31'b0, load_overflow}, 32'd0);
    check("skip_load_ready", {31'b0, c_ready}, 32'd0);
    check("skip_cpu_hold", {31'b0, c_hold}, 32'd0);

    // 8-byte program image
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("hold_before_last", {31'b0, cpu_hold}, 32'd1);
      send_a(prog8[i], i == 7);
    end
    check("hold_after_last", {31'b0, cpu_hold}, 32'd0);
    check("ready_after_last", {31'b0, load_ready}, 32'd0);
    addr_1 = 30'd0;
    #1 check("prog_word0", read_1, 32'h0000_0013);
    addr_1 = 30'd1;
    #1 check("prog_word1", read_1, 32'h0010_0093);

    // 5-byte image with partial last word
    reset_a();
    for (int i = 0; i < 5; i++) send_a(prog5[i], i == 4);
    check("five_run", {31'b0, cpu_hold}, 32'd0);
    addr_2 = 30'd0;
    #1 check("five_word0", read_2, 32'hDDCC_BBAA);
    addr_2 = 30'd1;
    #1 check("five_word1", read_2, 32'h0000_00EE);

    // RUN-mode writes
    addr_2 = 30'd4; write_2 = 32'h1122_3344; {we4, we3, we2, we1} = 4'b1111;
    tick();
    addr_2 = 30'd5; write_2 = 32'h5566_7788;
    tick();
    {we4, we3, we2, we1} = 4'b0000; addr_2 = 30'd4;
    #1 check("word4_full", read_2, 32'h1122_3344);
    write_2 = 32'hA5A5_A5A5; {we4, we3, we2, we1} = 4'b0110; addr_1 = 30'd4;
    #1 check("word4_during_write_p2", read_2, 32'h1122_3344);
    check("word4_during_write_p1", read_1, 32'h1122_3344);
    tick();
    {we4, we3, we2, we1} = 4'b0000;
    check("word4_lanes", read_2, 32'h11A5_A544);

    // Out-of-range access
    addr_2 = 30'h400; addr_1 = 30'h400;
    #1 check("oor_read_2", read_2, 32'h0);
    check("oor_read_1", read_1, 32'h0);
    write_2 = 32'hDEAD_BEEF; {we4, we3, we2, we1} = 4'b1111;
    tick();
    {we4, we3, we2, we1} = 4'b0000; addr_2 = 30'd0;
    #1 check("oor_write_dropped", read_2, 32'hDDCC_BBAA);

    // Reset in RUN keeps the array; CPU writes ignored in LOAD; reset mid-load
    reset_a();
    addr_1 = 30'd4;
    #1 check("rerun_hold", {31'b0, cpu_hold}, 32'd1);
    check("array_kept", read_1, 32'h11A5_A544);
    addr_2 = 30'd5; write_2 = 32'hFFFF_FFFF; {we4, we3, we2, we1} = 4'b1111;
    addr_1 = 30'd0;
    for (int i = 0; i < 6; i++) begin
      send_a(8'h10 * 8'(i + 1), 1'b0);
      tick();
      if (i == 3) check("gap_word0", read_1, 32'h4030_2010);
    end
    reset_a();
    for (int i = 0; i < 4; i++) send_a(8'(i + 1), i == 3);
    {we4, we3, we2, we1} = 4'b0000;
    addr_1 = 30'd0;
    #1 check("reload_word0", read_1, 32'h0403_0201);
    addr_1 = 30'd1;
    #1 check("reload_word1", read_1, 32'h0000_00EE);
    check("reload_overflow", {31'b0, load_overflow}, 32'd0);
    check("reload_run", {31'b0, cpu_hold}, 32'd0);
    check("load_we_ignored", read_2, 32'h5566_7788);

    // Overflow on a 4-word array
    for (int i = 0; i < 16; i++) begin
      b_valid = 1'b1;
      b_byte  = 8'(i);
      tick();
      if (i == 14) begin
        check("ovf_before", {31'b0, b_overflow}, 32'd0);
        check("ovf_ready_before", {31'b0, b_ready}, 32'd1);
      end
    end
    check("ovf_set", {31'b0, b_overflow}, 32'd1);
    check("ovf_run", {31'b0, b_hold}, 32'd0);
    check("ovf_ready", {31'b0, b_ready}, 32'd0);
    b_byte = 8'hAA;
    tick();
    b_valid = 1'b0;
    b_addr_1 = 30'd0; b_addr_2 = 30'd3;
    #1 check("ovf_word0", b_read_1, 32'h0302_0100);
    check("ovf_word3", b_read_2, 32'h0F0E_0D0C);
    check("ovf_sticky", {31'b0, b_overflow}, 32'd1);
    b_addr_2 = 30'd4;
    #1 check("ovf_oor", b_read_2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
